// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and timing defaults for the SPI mode-0 master
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    LAG   = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  localparam int CPOL = 0;
  localparam int CPHA = 0;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_SCK_HALF_CYCLES = 8;
  localparam int DEF_CS_LEAD_CYCLES  = 16;
  localparam int DEF_CS_LAG_CYCLES   = 8;
  localparam int DEF_CS_IDLE_CYCLES  = 8;

endpackage

// File: rtl/spi_mode0_master_if.sv
// rtl/spi_mode0_master_if.sv - request/response and SPI pin bundle for the mode-0 master
interface spi_mode0_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cs_n;
  logic                  sck;
  logic                  si;
  logic                  so;
  logic                  start_transfer;
  logic [DATA_WIDTH-1:0] data_to_send;
  logic [DATA_WIDTH-1:0] data_received;
  logic                  transfer_done;

  modport master (
    output cs_n, sck, si, data_received, transfer_done,
    input  so, start_transfer, data_to_send
  );

  modport slave (
    input  cs_n, sck, si, data_received, transfer_done,
    output so, start_transfer, data_to_send
  );
endinterface

// File: rtl/spi_sck_div.sv
// rtl/spi_sck_div.sv - sck half-period divider emitting rise/fall enables and a fall count
module spi_sck_div #(
  parameter int HALF_CYCLES = 8,
  parameter int EDGES       = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  output logic                           rise_en,
  output logic                           fall_en,
  output logic [$clog2(EDGES+1)-1:0]     fall_cnt
);
  localparam int HW = $clog2(HALF_CYCLES);
  localparam int EW = $clog2(EDGES + 1);

  logic [HW-1:0] half_cnt;
  logic          phase;
  logic          tick;

  // phase mirrors the sck level the top will drive; low half comes first
  assign tick    = en && (half_cnt == HW'(HALF_CYCLES - 1));
  assign rise_en = tick && !phase;
  assign fall_en = tick && phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      phase    <= 1'b0;
      fall_cnt <= '0;
    end else if (!en) begin
      half_cnt <= '0;
      phase    <= 1'b0;
      fall_cnt <= '0;
    end else if (tick) begin
      half_cnt <= '0;
      phase    <= ~phase;
      if (phase) fall_cnt <= fall_cnt + EW'(1);
    end else begin
      half_cnt <= half_cnt + HW'(1);
    end
  end

endmodule

// File: rtl/spi_mode0_master.sv
// rtl/spi_mode0_master.sv - SPI mode-0 master PHY, MSB first, one full-duplex frame per start
module spi_mode0_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int SCK_HALF_CYCLES = DEF_SCK_HALF_CYCLES,
  parameter int CS_LEAD_CYCLES  = DEF_CS_LEAD_CYCLES,
  parameter int CS_LAG_CYCLES   = DEF_CS_LAG_CYCLES,
  parameter int CS_IDLE_CYCLES  = DEF_CS_IDLE_CYCLES
) (
  input logic                clk,
  input logic                rst_n,
  spi_mode0_master_if.master bus
);
  localparam int EW = $clog2(DATA_WIDTH + 1);

  spi_state_e            state, state_d;
  logic [15:0]           cnt, cnt_d;
  logic                  accept, finish;
  logic                  rise_en, fall_en, last_fall;
  logic [EW-1:0]         fall_cnt;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift;

  spi_sck_div #(
    .HALF_CYCLES (SCK_HALF_CYCLES),
    .EDGES       (DATA_WIDTH)
  ) u_sck_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state == SHIFT),
    .rise_en  (rise_en),
    .fall_en  (fall_en),
    .fall_cnt (fall_cnt)
  );

  assign last_fall = fall_en && (fall_cnt == EW'(DATA_WIDTH - 1));

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 16'd1;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (bus.start_transfer) begin
          accept  = 1'b1;
          state_d = LEAD;
        end
      end
      LEAD: begin
        if (cnt == 16'(CS_LEAD_CYCLES - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        cnt_d = '0;
        if (last_fall) state_d = LAG;
      end
      LAG: begin
        if (cnt == 16'(CS_LAG_CYCLES - 1)) begin
          finish  = 1'b1;
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt == 16'(CS_IDLE_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      tx_shift          <= '0;
      rx_shift          <= '0;
      bus.cs_n          <= 1'b1;
      bus.sck           <= 1'(CPOL);
      bus.si            <= 1'b0;
      bus.data_received <= '0;
      bus.transfer_done <= 1'b0;
    end else begin
      state             <= state_d;
      cnt               <= cnt_d;
      bus.transfer_done <= finish;
      if (accept) begin
        tx_shift <= bus.data_to_send;
        bus.cs_n <= 1'b0;
        bus.si   <= bus.data_to_send[DATA_WIDTH-1];
      end
      if (rise_en) begin
        bus.sck  <= 1'b1;
        rx_shift <= {rx_shift[DATA_WIDTH-2:0], bus.so};
      end
      // si is left alone on the final fall so the slave's hold time is generous
      if (fall_en) begin
        bus.sck <= 1'b0;
        if (!last_fall) begin
          tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
          bus.si   <= tx_shift[DATA_WIDTH-2];
        end
      end
      if (finish) begin
        bus.cs_n          <= 1'b1;
        bus.si            <= 1'b0;
        bus.data_received <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_spi_mode0_master.sv
// tb/tb_spi_mode0_master.sv - self-checking bench with slave model and frame timing monitor
module tb_spi_mode0_master;

  localparam int W    = 8;
  localparam int HALF = 8;
  localparam int LEAD = 16;
  localparam int LAG  = 8;
  localparam int GAPC = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_mode0_master_if #(.DATA_WIDTH(W)) bus ();

  spi_mode0_master #(
    .DATA_WIDTH      (W),
    .SCK_HALF_CYCLES (HALF),
    .CS_LEAD_CYCLES  (LEAD),
    .CS_LAG_CYCLES   (LAG),
    .CS_IDLE_CYCLES  (GAPC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  // slave model: MSB presented at cs_n fall, next bit after each sck fall, si sampled on rises
  logic [W-1:0] slave_tx = '0;
  logic [W-1:0] slave_rx = '0;
  int           slave_idx = 0;

  always @(negedge bus.cs_n) begin
    slave_idx = 0;
    slave_rx  = '0;
    bus.so    = slave_tx[W-1];
  end
  always @(posedge bus.sck) slave_rx = {slave_rx[W-2:0], bus.si};
  always @(negedge bus.sck) begin
    if (!bus.cs_n) begin
      slave_idx = slave_idx + 1;
      if (slave_idx < W) bus.so = slave_tx[W-1-slave_idx];
    end
  end

  // timing monitor sampled mid-cycle
  int cyc = 0, t_csfall = 0, t_csrise = 0, t_rise1 = 0, t_rise2 = 0, t_lastfall = 0, t_done = 0;
  int rises = 0, falls = 0, done_cnt = 0, csfalls = 0, dr_glitch = 0;
  logic [W-1:0] rx_at_done = '0;
  logic prev_cs = 1'b1, prev_sck = 1'b0, prev_rst = 1'b0;
  logic [W-1:0] prev_dr = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_cs && !bus.cs_n) begin
      t_csfall = cyc; rises = 0; falls = 0; csfalls = csfalls + 1;
    end
    if (!prev_cs && bus.cs_n) t_csrise = cyc;
    if (!prev_sck && bus.sck) begin
      rises = rises + 1;
      if (rises == 1) t_rise1 = cyc;
      if (rises == 2) t_rise2 = cyc;
    end
    if (prev_sck && !bus.sck) begin
      falls = falls + 1; t_lastfall = cyc;
    end
    if (bus.transfer_done === 1'b1) begin
      done_cnt = done_cnt + 1; t_done = cyc; rx_at_done = bus.data_received;
    end
    if (rst_n && prev_rst && (bus.data_received !== prev_dr) && (bus.transfer_done !== 1'b1))
      dr_glitch = dr_glitch + 1;
    prev_cs  = bus.cs_n;
    prev_sck = bus.sck;
    prev_rst = rst_n;
    prev_dr  = bus.data_received;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_frame(input logic [W-1:0] tx, input logic [W-1:0] stx,
                          input int hold, input bit mid_pulse);
    int d0, f0;
    slave_tx = stx;
    d0 = done_cnt;
    f0 = csfalls;
    @(negedge clk);
    bus.start_transfer = 1'b1;
    bus.data_to_send   = tx;
    repeat (hold) @(negedge clk);
    bus.start_transfer = 1'b0;
    bus.data_to_send   = W'($urandom);
    if (mid_pulse) begin
      repeat (50) @(negedge clk);
      bus.start_transfer = 1'b1;
      bus.data_to_send   = ~tx;
      @(negedge clk);
      bus.start_transfer = 1'b0;
      repeat (40) @(negedge clk);
      bus.data_to_send   = ~tx;
    end
    for (int i = 0; i < 600 && done_cnt == d0; i++) @(negedge clk);
    chk("done_seen", 32'(done_cnt - d0), 32'd1);
    repeat (GAPC + 4) @(negedge clk);
    chk("done_single", 32'(done_cnt - d0), 32'd1);
    chk("one_frame", 32'(csfalls - f0), 32'd1);
    chk("slave_rx", 32'(slave_rx), 32'(tx));
    chk("data_received", 32'(rx_at_done), 32'(stx));
    chk("rises", 32'(rises), 32'(W));
    chk("falls", 32'(falls), 32'(W));
    chk("lead_to_rise", 32'(t_rise1 - t_csfall), 32'(LEAD + HALF));
    chk("sck_period", 32'(t_rise2 - t_rise1), 32'(2 * HALF));
    chk("lag", 32'(t_csrise - t_lastfall), 32'(LAG));
    chk("done_at_cs_rise", 32'(t_done), 32'(t_csrise));
    chk("cs_low_len", 32'(t_csrise - t_csfall), 32'(LEAD + 2 * HALF * W + LAG));
  endtask

  initial begin
    int d0;
    logic [W-1:0] a, b;
    rst_n              = 1'b0;
    bus.start_transfer = 1'b0;
    bus.data_to_send   = '0;
    bus.so             = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(bus.cs_n), 32'd1);
    chk("rst_sck", 32'(bus.sck), 32'd0);
    chk("rst_si", 32'(bus.si), 32'd0);
    chk("rst_dr", 32'(bus.data_received), 32'd0);
    chk("rst_done", 32'(bus.transfer_done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_frame(8'hA5, 8'h00, 1, 1'b0);
    do_frame(8'h5A, 8'h00, 1, 1'b0);
    do_frame(8'h00, 8'hB6, 1, 1'b0);
    do_frame(8'hA5, 8'hB6, 1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      do_frame(a, b, 1 + (k % 2), 1'b0);
    end
    do_frame(8'hC3, 8'h69, 2, 1'b1);

    // abort mid-SHIFT
    d0 = done_cnt;
    slave_tx = 8'hFF;
    @(negedge clk);
    bus.start_transfer = 1'b1;
    bus.data_to_send   = 8'h81;
    @(negedge clk);
    bus.start_transfer = 1'b0;
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(bus.cs_n), 32'd1);
    chk("abort_sck", 32'(bus.sck), 32'd0);
    chk("abort_dr", 32'(bus.data_received), 32'd0);
    chk("abort_done", 32'(bus.transfer_done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    do_frame(8'h3C, 8'hE7, 1, 1'b0);

    chk("dr_stable", 32'(dr_glitch), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
